bitmap_record_writer: RTL and testbench
=======================================

// Module: bitmap_record_writer
// PURPOSE
//  Writer side of the bitmap record format consumed by the bitmap renderer.
//  Takes a record header plus a serial stream of pixel bits and writes the
//  packed record into the bitmap RAM write port, word by word. Used for runtime
//  bitmaps (score, messages); sits between the game logic and the RAM.
//  Record layout (10-bit words, from BASE_ADDR):
//  +0 startX, +1 startY, +2 colCount, +3 rowCount,
//  +4 {blockSize[3:0], blink, 5'b0}, +5.. pixel data.
// PARAMETERS
//  ADDR_BITS  10  width of RAM word address; all address arithmetic is mod 2^ADDR_BITS
// PORTS
//  CLK         in   1          clock
//  RESET       in   1          synchronous, active-high reset
//  START       in   1          begin a record; sampled only in IDLE
//  BASE_ADDR   in   ADDR_BITS  first word address of record
//  START_X     in   10         header word 0
//  START_Y     in   10         header word 1
//  COL_COUNT   in   10         header word 2 (blocks per row)
//  ROW_COUNT   in   10         header word 3 (rows)
//  BLOCK_SIZE  in   4          header word 4 [9:6]
//  BLINK       in   1          header word 4 [5]
//  PIX_VALID   in   1          pixel bit offered
//  PIX_DATA    in   1          pixel bit, row-major, leftmost first
//  PIX_READY   out  1          pixel accepted when PIX_VALID && PIX_READY
//  WE          out  1          RAM write strobe
//  WADDR       out  ADDR_BITS  RAM write address
//  WDATA       out  10         RAM write data
//  BUSY        out  1          high from START acceptance until DONE
//  DONE        out  1          one-cycle pulse, record complete
//  NEXT_ADDR   out  ADDR_BITS  address after last written word; valid at DONE
// BEHAVIOUR
//  - Reset: state IDLE; PIX_READY, WE, BUSY, DONE = 0; WADDR, WDATA, NEXT_ADDR = 0.
//    Takes effect mid-record; a partial record is abandoned and no further writes occur.
//  - START, header inputs, and BASE_ADDR are sampled in the IDLE cycle with START=1.
//    The product total = COL_COUNT*ROW_COUNT (20 bit) is latched in the same cycle.
//  - HDR: 5 cycles with WE=1, WADDR = BASE_ADDR+0..4, header words in order.
//    The first write is in the cycle after START. Unused bits of word 4 are 0.
//  - After HDR:
//    - total==0: go to FIN; no data words.
//    - otherwise: go to PIX, PIX_READY=1.
//  - PIX: bits pack MSB-first (bit 9 first, bit 0 last). Bits continue across row
//    boundaries with no per-row padding.
//  - Word completion: a word is complete when its 10th bit is accepted or the last
//    (total-th) pixel is accepted. Unfilled low bits are 0.
//  - Word write: in the cycle after completion, WE=1 with the next data address
//    (BASE_ADDR+5, +6, ...). PIX_READY stays 1 during the write, so throughput is
//    1 bit/cycle.
//  - After the last pixel is accepted: PIX_READY drops the next cycle and the final
//    word is written that cycle, then go to FIN.
//  - Data word count = ceil(total/10).
//  - FIN: DONE=1 for 1 cycle; NEXT_ADDR = BASE_ADDR+5+ceil(total/10); BUSY=0 next
//    cycle; return to IDLE.
//  - START while BUSY is ignored. PIX_VALID outside PIX is ignored. WE=0 whenever
//    not writing.
//  - Address wrap past 2^ADDR_BITS-1 continues at 0; no error flagged.
// TESTING
//  1. Basic record: BASE=0, X=100, Y=50, cols=4, rows=3, size=2, blink=1, bits 1010..;
//     expect:
//     - header writes 100, 50, 4, 3, 10'b0010_1_00000 at addr 0-4;
//     - data 0x2AA @5 and 10'b1000000000 @6;
//     - NEXT_ADDR=7, DONE one pulse.
//  2. Exact fill: cols=5, rows=2, all ones -> one data word 0x3FF @BASE+5,
//     NEXT_ADDR=BASE+6.
//  3. Zero size: cols=0, rows=7 -> 5 header writes only, PIX_READY never 1,
//     NEXT_ADDR=BASE+5.
//  4. Backpressure/gaps: PIX_VALID toggling every cycle, 23 pixels -> identical
//     words to the gap-free run, 3 data writes, the last with bits [6:0]=0.
//  5. Wrap and reset: BASE=2^ADDR_BITS-3 -> header addresses wrap to 0, 1.
//     RESET asserted mid-PIX -> WE=0 next cycle, IDLE, and a new START is then
//     accepted normally.
//  6. START while BUSY and a second START right after DONE -> the first is ignored;
//     the second record starts at the supplied BASE with correct contents.

Source files
------------

// File: rtl/bitmap_record_writer_if.sv
// Bitmap record writer bus: record request, pixel stream and RAM write port.
// The master side is the game logic; the slave side is the record writer,
// which also drives the RAM write strobe, address and data.
interface bitmap_record_writer_if #(
  parameter int ADDR_BITS = 10
);
  logic                 START;
  logic [ADDR_BITS-1:0] BASE_ADDR;
  logic [9:0]           START_X;
  logic [9:0]           START_Y;
  logic [9:0]           COL_COUNT;
  logic [9:0]           ROW_COUNT;
  logic [3:0]           BLOCK_SIZE;
  logic                 BLINK;
  logic                 PIX_VALID;
  logic                 PIX_DATA;
  logic                 PIX_READY;
  logic                 WE;
  logic [ADDR_BITS-1:0] WADDR;
  logic [9:0]           WDATA;
  logic                 BUSY;
  logic                 DONE;
  logic [ADDR_BITS-1:0] NEXT_ADDR;

  modport master (
    output START, BASE_ADDR, START_X, START_Y, COL_COUNT, ROW_COUNT,
           BLOCK_SIZE, BLINK, PIX_VALID, PIX_DATA,
    input  PIX_READY, WE, WADDR, WDATA, BUSY, DONE, NEXT_ADDR
  );

  modport slave (
    input  START, BASE_ADDR, START_X, START_Y, COL_COUNT, ROW_COUNT,
           BLOCK_SIZE, BLINK, PIX_VALID, PIX_DATA,
    output PIX_READY, WE, WADDR, WDATA, BUSY, DONE, NEXT_ADDR
  );
endinterface

// File: rtl/bitmap_record_writer.sv
// Bitmap record writer: writes a 5-word header followed by MSB-first packed
// pixel words into the bitmap RAM, one word per cycle at most. All outputs
// are registered; address arithmetic wraps naturally at ADDR_BITS.
module bitmap_record_writer #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 CLK,
  input  logic                 RESET,
  bitmap_record_writer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HDR, PIX, LAST, FIN} stateT;

  localparam logic [9:0] MSB_ONE = 10'h200;

  stateT                stateReg;
  logic [ADDR_BITS-1:0] baseAddrReg;
  logic [ADDR_BITS-1:0] dataAddrReg;
  logic [9:0]           hdrWordReg [0:4];
  logic [2:0]           hdrIdxReg;
  logic [19:0]          totalReg;
  logic [19:0]          pixCountReg;
  logic [9:0]           wordAccReg;
  logic [3:0]           bitPosReg;

  logic       pixAccept;
  logic       lastPix;
  logic       wordDone;
  logic [9:0] wordWithBit;

  // Pixel acceptance and word-completion decode for the current cycle.
  always_comb begin
    pixAccept   = (stateReg == PIX) && bus.PIX_VALID && bus.PIX_READY;
    lastPix     = (pixCountReg + 20'd1) == totalReg;
    wordDone    = (bitPosReg == 4'd9) || lastPix;
    wordWithBit = wordAccReg | (bus.PIX_DATA ? (MSB_ONE >> bitPosReg) : 10'd0);
  end

  // Record sequencer: header words, pixel packing, final word, done pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stateReg      <= IDLE;
      baseAddrReg   <= '0;
      dataAddrReg   <= '0;
      hdrIdxReg     <= '0;
      totalReg      <= '0;
      pixCountReg   <= '0;
      wordAccReg    <= '0;
      bitPosReg     <= '0;
      for (int i = 0; i < 5; i++) hdrWordReg[i] <= '0;
      bus.PIX_READY <= 1'b0;
      bus.WE        <= 1'b0;
      bus.WADDR     <= '0;
      bus.WDATA     <= '0;
      bus.BUSY      <= 1'b0;
      bus.DONE      <= 1'b0;
      bus.NEXT_ADDR <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          bus.WE <= 1'b0;
          if (bus.START) begin
            // Latch everything now; header word 0 goes out immediately.
            baseAddrReg   <= bus.BASE_ADDR;
            dataAddrReg   <= bus.BASE_ADDR + ADDR_BITS'(5);
            hdrWordReg[0] <= bus.START_X;
            hdrWordReg[1] <= bus.START_Y;
            hdrWordReg[2] <= bus.COL_COUNT;
            hdrWordReg[3] <= bus.ROW_COUNT;
            hdrWordReg[4] <= {bus.BLOCK_SIZE, bus.BLINK, 5'b0};
            totalReg      <= 20'(bus.COL_COUNT) * 20'(bus.ROW_COUNT);
            pixCountReg   <= '0;
            wordAccReg    <= '0;
            bitPosReg     <= '0;
            hdrIdxReg     <= 3'd1;
            bus.WE        <= 1'b1;
            bus.WADDR     <= bus.BASE_ADDR;
            bus.WDATA     <= bus.START_X;
            bus.BUSY      <= 1'b1;
            stateReg      <= HDR;
          end
        end
        HDR: begin
          if (hdrIdxReg != 3'd5) begin
            bus.WE    <= 1'b1;
            bus.WADDR <= baseAddrReg + ADDR_BITS'(hdrIdxReg);
            bus.WDATA <= hdrWordReg[hdrIdxReg];
            hdrIdxReg <= hdrIdxReg + 3'd1;
          end else begin
            bus.WE <= 1'b0;
            if (totalReg == '0) begin
              bus.DONE      <= 1'b1;
              bus.NEXT_ADDR <= dataAddrReg;
              stateReg      <= FIN;
            end else begin
              bus.PIX_READY <= 1'b1;
              stateReg      <= PIX;
            end
          end
        end
        PIX: begin
          bus.WE <= 1'b0;
          if (pixAccept) begin
            pixCountReg <= pixCountReg + 20'd1;
            if (wordDone) begin
              // Word full (or last pixel): write it next cycle, low bits stay 0.
              bus.WE      <= 1'b1;
              bus.WADDR   <= dataAddrReg;
              bus.WDATA   <= wordWithBit;
              dataAddrReg <= dataAddrReg + ADDR_BITS'(1);
              wordAccReg  <= '0;
              bitPosReg   <= '0;
              if (lastPix) begin
                bus.PIX_READY <= 1'b0;
                stateReg      <= LAST;
              end
            end else begin
              wordAccReg <= wordWithBit;
              bitPosReg  <= bitPosReg + 4'd1;
            end
          end
        end
        LAST: begin
          bus.WE        <= 1'b0;
          bus.DONE      <= 1'b1;
          bus.NEXT_ADDR <= dataAddrReg;
          stateReg      <= FIN;
        end
        FIN: begin
          bus.WE   <= 1'b0;
          bus.DONE <= 1'b0;
          bus.BUSY <= 1'b0;
          stateReg <= IDLE;
        end
        default: begin
          bus.WE   <= 1'b0;
          stateReg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitmap_record_writer.sv
// Bench for bitmap_record_writer: a scoreboard of expected RAM writes is
// filled from a reference packing model when each record is driven, and a
// monitor pops and compares every write the DUT makes.
module tb_bitmap_record_writer;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  bitmap_record_writer_if #(.ADDR_BITS(10)) bus();

  bitmap_record_writer #(.ADDR_BITS(10)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int          assertCount = 0;
  int          failCount   = 0;
  logic [19:0] expQ[$];
  bit          pixQ[$];
  int          writeCount;
  bit          readySeen;
  logic [19:0] monExp;

  // Count one comparison and report it when it does not match.
  task automatic assertEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every RAM write must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (RESET === 1'b0) begin
      if (bus.PIX_READY) readySeen = 1'b1;
      if (bus.WE) begin
        writeCount++;
        $display("write addr=%0d data=0x%03h", bus.WADDR, bus.WDATA);
        assertEq("writeExpected", 32'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          monExp = expQ.pop_front();
          assertEq("waddr", bus.WADDR, monExp[19:10]);
          assertEq("wdata", bus.WDATA, monExp[9:0]);
        end
      end
    end
  end

  task automatic fillPix(input int mode, input int n);
    pixQ.delete();
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       pixQ.push_back(i % 2 == 0);
        1:       pixQ.push_back(1'b1);
        default: pixQ.push_back(1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  // Drive one record; abortAfter >= 0 resets the DUT after that many pixels.
  task automatic runRecord(input logic [9:0] base, input logic [9:0] x, input logic [9:0] y,
                           input logic [9:0] cols, input logic [9:0] rows,
                           input logic [3:0] size, input bit blink, input bit gaps,
                           input bit ghost, input int abortAfter);
    int         total, words, nWords, nFeed, idx;
    logic [9:0] d, expNext;
    bit         seen, ok, rdy;
    total = int'(cols) * int'(rows);
    words = (total + 9) / 10;
    expQ.push_back({base,          x});
    expQ.push_back({base + 10'd1,  y});
    expQ.push_back({base + 10'd2,  cols});
    expQ.push_back({base + 10'd3,  rows});
    expQ.push_back({base + 10'd4,  size, blink, 5'b0});
    nWords = (abortAfter < 0) ? words : abortAfter / 10;
    for (int w = 0; w < nWords; w++) begin
      d = '0;
      for (int b = 0; b < 10; b++) begin
        idx = w * 10 + b;
        if (idx < total && pixQ[idx]) d[9-b] = 1'b1;
      end
      expQ.push_back({base + 10'(5 + w), d});
    end
    expNext    = base + 10'(5 + words);
    writeCount = 0;
    readySeen  = 1'b0;
    $display("record base=%0d cols=%0d rows=%0d gaps=%0d ghost=%0d abort=%0d",
             base, cols, rows, gaps, ghost, abortAfter);

    bus.START      = 1'b1;
    bus.BASE_ADDR  = base;
    bus.START_X    = x;
    bus.START_Y    = y;
    bus.COL_COUNT  = cols;
    bus.ROW_COUNT  = rows;
    bus.BLOCK_SIZE = size;
    bus.BLINK      = blink;
    @(posedge CLK); #1;
    if (ghost) begin
      bus.BASE_ADDR = base ^ 10'h155;
      bus.START_X   = ~x;
      bus.COL_COUNT = cols + 10'd3;
      @(posedge CLK); #1;
    end
    bus.START = 1'b0;

    nFeed = (abortAfter < 0) ? total : abortAfter;
    for (int i = 0; i < nFeed; i++) begin
      if (gaps) begin
        bus.PIX_VALID = 1'b0;
        @(posedge CLK); #1;
      end
      bus.PIX_VALID = 1'b1;
      bus.PIX_DATA  = pixQ[i];
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        rdy = bus.PIX_READY;
        @(posedge CLK); #1;
        if (rdy) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        assertEq("pixAccepted", 32'(ok), 1);
        break;
      end
    end
    bus.PIX_VALID = 1'b0;

    if (abortAfter >= 0) begin
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(negedge CLK);
      assertEq("abortWe",    32'(bus.WE), 0);
      assertEq("abortBusy",  32'(bus.BUSY), 0);
      assertEq("abortReady", 32'(bus.PIX_READY), 0);
      assertEq("abortDone",  32'(bus.DONE), 0);
      assertEq("abortPending", 32'(expQ.size()), 0);
      expQ.delete();
    end else begin
      seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge CLK);
        if (bus.DONE) begin
          seen = 1'b1;
          break;
        end
      end
      assertEq("doneSeen", 32'(seen), 1);
      if (seen) begin
        assertEq("nextAddr",   bus.NEXT_ADDR, expNext);
        assertEq("busyAtDone", 32'(bus.BUSY), 1);
        @(negedge CLK);
        assertEq("donePulse",  32'(bus.DONE), 0);
        assertEq("busyAfter",  32'(bus.BUSY), 0);
      end
      assertEq("writeCount", 32'(writeCount), 32'(5 + words));
      assertEq("pending", 32'(expQ.size()), 0);
      if (total == 0) assertEq("readyNeverHigh", 32'(readySeen), 0);
      expQ.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET          = 1'b1;
    bus.START      = 1'b0;
    bus.BASE_ADDR  = '0;
    bus.START_X    = '0;
    bus.START_Y    = '0;
    bus.COL_COUNT  = '0;
    bus.ROW_COUNT  = '0;
    bus.BLOCK_SIZE = '0;
    bus.BLINK      = 1'b0;
    bus.PIX_VALID  = 1'b0;
    bus.PIX_DATA   = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    assertEq("rstWe",       32'(bus.WE), 0);
    assertEq("rstBusy",     32'(bus.BUSY), 0);
    assertEq("rstDone",     32'(bus.DONE), 0);
    assertEq("rstReady",    32'(bus.PIX_READY), 0);
    assertEq("rstWaddr",    bus.WADDR, 0);
    assertEq("rstWdata",    bus.WDATA, 0);
    assertEq("rstNextAddr", bus.NEXT_ADDR, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Basic record with alternating pixels
    fillPix(0, 12);
    runRecord(10'd0, 10'd100, 10'd50, 10'd4, 10'd3, 4'd2, 1'b1, 1'b0, 1'b0, -1);
    // Exact fill of one word
    fillPix(1, 10);
    runRecord(10'd40, 10'd7, 10'd9, 10'd5, 10'd2, 4'd15, 1'b0, 1'b0, 1'b0, -1);
    // Zero-size record
    fillPix(1, 0);
    runRecord(10'd100, 10'd1, 10'd2, 10'd0, 10'd7, 4'd3, 1'b1, 1'b0, 1'b0, -1);
    // Same 23 pixels gap-free and with VALID toggling
    fillPix(2, 23);
    runRecord(10'd200, 10'd300, 10'd400, 10'd23, 10'd1, 4'd1, 1'b0, 1'b0, 1'b0, -1);
    runRecord(10'd200, 10'd300, 10'd400, 10'd23, 10'd1, 4'd1, 1'b0, 1'b1, 1'b0, -1);
    // Address wrap through the top of RAM
    fillPix(2, 12);
    runRecord(10'd1021, 10'd5, 10'd6, 10'd3, 10'd4, 4'd8, 1'b1, 1'b1, 1'b0, -1);
    // Reset in the middle of pixel data, then a normal record
    fillPix(2, 100);
    runRecord(10'd600, 10'd11, 10'd22, 10'd10, 10'd10, 4'd4, 1'b0, 1'b0, 1'b0, 5);
    fillPix(2, 14);
    runRecord(10'd700, 10'd33, 10'd44, 10'd7, 10'd2, 4'd6, 1'b1, 1'b0, 1'b1, -1);
    // Back-to-back START right after DONE
    fillPix(2, 18);
    runRecord(10'd300, 10'd55, 10'd66, 10'd2, 10'd9, 4'd9, 1'b0, 1'b1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
